// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared access-size codes, FSM states and alignment check
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10,
        SIZE_X = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    function automatic logic misaligned(input size_e sz, input logic [1:0] off);
        return (sz == SIZE_X) || (sz == SIZE_H && off[0]) || (sz == SIZE_W && off != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte enables, store lane steering and load extract/extend
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  size_e       i_size,
    input  logic [1:0]  i_off,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wword,
    output logic [31:0] o_rdata
);
    logic [31:0] w_shift;

    assign w_shift = i_rword >> {i_off, 3'b000};
    assign o_be    = i_size == SIZE_B ? 4'b0001 << i_off :
                     i_size == SIZE_H ? 4'b0011 << i_off :
                     i_size == SIZE_W ? 4'b1111 : 4'b0000;
    // replicating the data puts it on every lane; the byte enables pick the real one
    assign o_wword = i_size == SIZE_B ? {4{i_wdata[7:0]}} :
                     i_size == SIZE_H ? {2{i_wdata[15:0]}} : i_wdata;
    assign o_rdata = i_size == SIZE_B ? {{24{~i_unsigned & w_shift[7]}}, w_shift[7:0]} :
                     i_size == SIZE_H ? {{16{~i_unsigned & w_shift[15]}}, w_shift[15:0]} : i_rword;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: word-array data memory with valid/ready request and response
// channels, configurable wait states and lane-aware loads/stores.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 1
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err
);
    localparam int         DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [3:0] LAST_WAIT = 4'(WAIT_CYCLES - 1);

    state_e      r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    size_e       r_size;
    logic        r_unsigned;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_resp_valid;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem [DEPTH];

    logic                  w_idle;
    logic                  w_accept;
    logic                  w_to_resp;
    logic                  w_commit;
    logic                  w_we;
    size_e                 w_size;
    logic                  w_uns;
    logic [31:0]           w_addr;
    logic [31:0]           w_wdata;
    logic                  w_err;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [31:0]           w_rword;
    logic [3:0]            w_be;
    logic [31:0]           w_wword;
    logic [31:0]           w_rdata;

    assign w_idle      = r_state == ST_IDLE;
    assign o_req_ready = w_idle && rst_n;
    assign w_accept    = i_req_valid && o_req_ready;

    // With no wait states the store commits on the accept edge, straight from the port
    assign w_we    = w_idle ? i_req_we : r_we;
    assign w_size  = w_idle ? size_e'(i_req_size) : r_size;
    assign w_uns   = w_idle ? i_req_unsigned : r_unsigned;
    assign w_addr  = w_idle ? i_req_addr : r_addr;
    assign w_wdata = w_idle ? i_req_wdata : r_wdata;

    assign w_err     = misaligned(w_size, w_addr[1:0]) || |w_addr[31:ADDR_WIDTH+2];
    assign w_idx     = w_addr[ADDR_WIDTH+1:2];
    assign w_rword   = r_mem[w_idx];
    assign w_to_resp = (w_accept && WAIT_CYCLES == 0) || (r_state == ST_WAIT && r_cnt == LAST_WAIT);
    assign w_commit  = w_to_resp && w_we && !w_err;

    dmem_lane_align u_align (
        .i_size     (w_size),
        .i_off      (w_addr[1:0]),
        .i_unsigned (w_uns),
        .i_wdata    (w_wdata),
        .i_rword    (w_rword),
        .o_be       (w_be),
        .o_wword    (w_wword),
        .o_rdata    (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (w_commit)
            for (int i = 0; i < 4; i++)
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wword[8*i +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 4'd0;
            r_we         <= 1'b0;
            r_size       <= SIZE_B;
            r_unsigned   <= 1'b0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_resp_valid <= 1'b0;
            r_rdata      <= 32'd0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept) begin
                    r_we       <= i_req_we;
                    r_size     <= size_e'(i_req_size);
                    r_unsigned <= i_req_unsigned;
                    r_addr     <= i_req_addr;
                    r_wdata    <= i_req_wdata;
                    r_cnt      <= 4'd0;
                    r_state    <= WAIT_CYCLES == 0 ? ST_RESP : ST_WAIT;
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == LAST_WAIT) r_state <= ST_RESP;
                end
                ST_RESP: if (!r_resp_valid) begin
                    r_resp_valid <= 1'b1;
                    r_err        <= w_err;
                    r_rdata      <= (w_err || r_we) ? 32'd0 : w_rdata;
                end else if (i_resp_ready) begin
                    r_resp_valid <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_resp_valid = r_resp_valid;
    assign o_resp_rdata = r_rdata;
    assign o_resp_err   = r_err;
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter ADDR_WIDTH, 8, word-index bits; array depth is 2^ADDR_WIDTH 32-bit words (default 256 words, 1 KiB).
REQ-002 Parameter WAIT_CYCLES, 1, extra wait states between request accept and response (legal 0..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low; asserts immediately, deasserts synchronously to clk.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder accepts a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  access size code (byte / half / word / illegal), from the shared package.
REQ-009 req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
REQ-010 req_addr  input  32  byte address.
REQ-011 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 resp_valid  output  1  response available.
REQ-013 resp_ready  input  1  initiator consumes the response.
REQ-014 resp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-015 resp_err  output  1  request was rejected (misaligned, out of range, or illegal size).

Function
REQ-016 FSM states SHALL be IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 Accept occurs when req_valid && req_ready at a rising edge; req_* fields SHALL be captured into internal registers at that edge and ignored afterwards.
REQ-018 IDLE->WAIT on accept if WAIT_CYCLES>0, otherwise IDLE->RESP; WAIT counts WAIT_CYCLES edges, then ->RESP.
REQ-019 Latency: accept at edge N, resp_valid SHALL be 1 from edge N+WAIT_CYCLES+1 onward.
REQ-020 In RESP, resp_valid, resp_rdata and resp_err SHALL stay stable until resp_valid && resp_ready at an edge; the FSM then returns to IDLE and resp_valid drops.
REQ-021 Throughput SHALL be at most one request per WAIT_CYCLES+2 cycles; a new request is not accepted in the cycle of the response handshake.
REQ-022 Error: size code 11, half access with addr[0]=1, word access with addr[1:0]!=0, or addr >= 4*2^ADDR_WIDTH SHALL set resp_err=1 and resp_rdata=0, with no array write.
REQ-023 Stores SHALL write only the addressed byte lanes (byte enables from size and addr[1:0]); other lanes are preserved.
REQ-024 A store SHALL commit to the array on the edge that enters RESP, so that a following load observes it.
REQ-025 Loads SHALL read the word at addr[ADDR_WIDTH+1:2] and shift the selected lane to bit 0.
REQ-026 Loads SHALL sign- or zero-extend per req_unsigned; word loads ignore req_unsigned.
REQ-027 Array contents SHALL persist across any number of transactions.

Reset
REQ-028 On rst=0: state IDLE, wait counter 0, resp_valid 0, resp_rdata 0, resp_err 0, captured request registers 0.
REQ-029 While rst=0, req_ready SHALL be 0.
REQ-030 If reset asserts mid-transaction, the transaction SHALL be dropped with no response; an uncommitted store SHALL NOT write the array.
REQ-031 Array contents SHALL NOT be reset.

Structure
REQ-032 A shared package/header SHALL hold the size codes (SIZE_B=00, SIZE_H=01, SIZE_W=10) and the FSM state encodings.
REQ-033 One sub-module, dmem_lane_align, SHALL hold the combinational logic: byte-enable generation, store lane steering, and load extract/extend.

Verification
REQ-034 After reset, word store 0xDEADBEEF to 0x10, then signed word load from 0x10 -> resp_rdata=0xDEADBEEF, resp_err=0, resp_valid first high 2 cycles after accept (WAIT_CYCLES=1).
REQ-035 Byte store 0x80 to 0x11 over word 0x00000000, then signed byte load 0x11 -> 0xFFFFFF80, unsigned byte load -> 0x00000080, word load 0x10 -> 0x00008000.
REQ-036 Half load at 0x13, word load at 0x12, size=11 at 0x0, and word load at 0x400 (ADDR_WIDTH=8) -> resp_err=1, resp_rdata=0; prior contents unchanged.
REQ-037 Hold resp_ready=0 for 5 cycles during RESP -> resp_valid and data stable; req_ready stays 0 until the handshake edge.
REQ-038 Assert rst=0 in WAIT of a store to 0x20 (old value 0x11111111) -> resp_valid never rises, req_ready=0 during reset, later load of 0x20 -> 0x11111111.
REQ-039 Run with WAIT_CYCLES=0 and with WAIT_CYCLES=15 -> resp_valid 1 and 16 edges after accept, respectively; results identical.
